sar_mag_search: RTL
===================

// Module: sar_mag_search
// PURPOSE
//  Successive-approximation controller that works from the comparator side.
//  It drives a trial operand into an external magnitude comparator and reads
//  back its one-hot less/equal/greater result. It then binary-searches the
//  unknown operand on the comparator's other input, recovering the value in
//  at most WIDTH compare steps.
// PARAMETERS
//  WIDTH   4  operand width in bits; also the maximum number of compare steps
//  SETTLE  0  extra idle cycles after each trial change, before the result is sampled
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      1-cycle request to begin a search; honoured only in IDLE
//  trial   out  WIDTH  registered trial operand, fed to the comparator's b input
//  cmp_gt  in   1      comparator: target > trial
//  cmp_eq  in   1      comparator: target == trial
//  cmp_lt  in   1      comparator: target < trial
//  busy    out  1      high from the cycle after start until done
//  done    out  1      1-cycle pulse: result and err are valid
//  result  out  WIDTH  recovered target value; held until the next accepted start
//  err     out  1      comparator fault in the last search; held until the next start
// BEHAVIOUR
//  Reset: state=IDLE; trial=0, result=0, busy=0, done=0, err=0; settle counter=0.
//  States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE:
//   - start=1: acc=0, idx=WIDTH-1, trial=1<<(WIDTH-1), busy=1, err=0,
//     scnt=SETTLE; go to SETTLE.
//   - With SETTLE=0, SETTLE passes through in 0 cycles (go straight to SAMPLE).
//  SETTLE: decrement scnt each cycle; at 0 go to SAMPLE.
//  SAMPLE: the cmp_* inputs are sampled on this edge.
//   - eq only: result=trial; go to DONE.
//   - gt only:
//     - idx>0: acc=trial (keep bit), idx-1, trial=acc|1<<(idx-1).
//     - idx==0: impossible for a consistent search; err=1, result=trial; go to DONE.
//   - lt only:
//     - idx>0: acc unchanged (drop bit), idx-1, trial=acc|1<<(idx-1).
//     - idx==0: result=acc; go to DONE.
//   - Not one-hot (zero bits or more than one set): err=1, result=acc; go to DONE.
//   - Every trial change reloads scnt=SETTLE.
//  DONE: done=1 for exactly 1 cycle, busy=0; trial holds its last value; go to IDLE.
//  Latency: accepting edge to done high = k*(SETTLE+1)+1 cycles, k = compare steps (1..WIDTH).
//  start while busy or in DONE: ignored, with no effect on the search in progress.
//  cmp_* inputs are ignored outside SAMPLE.
//  rst_n low at any time: immediate return to reset values; the search is lost
//   and no done pulse is produced.
//  All arithmetic is WIDTH-bit unsigned; no bit of trial is ever set above WIDTH-1.
// TESTING
//  (Bench model: cmp_* = combinational compare of a hidden target vs trial.)
//  1 W=4,S=0, target 9: trials 8,12,10,9; 4 steps; done at cycle 5; result=9, err=0.
//  2 target 8: eq on the first trial; done at cycle 2; result=8.
//    target 0: trials 8,4,2,1 all lt; result=0.
//    target 15: trials 8,12,14,15; eq on the 4th; result=15.
//  3 Force cmp_*=000 at the 2nd SAMPLE (target 9): done; err=1; result=8.
//    Separately, cmp gt at idx 0: err=1.
//  4 SETTLE=2, target 5: trials 8,4,6,5; each held for 3 cycles; done at cycle 13; result=5.
//  5 Re-pulse start mid-search: the search is unchanged and only one done is produced.
//    Then assert rst_n low at step 2: all outputs return to 0, state=IDLE, no done pulse.
//  6 Exhaustive: W=4, S=0 and S=1, all 16 targets: result==target, err=0,
//    step count <=4 on every search.

Source files
------------

// File: rtl/sar_mag_search_if.sv
// Handshake and comparator bus between the SAR search controller and its environment.
// The master side is the controller; the slave side holds the comparator and requester.
interface sar_mag_search_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] trial;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             err;

   modport master (
      input  start, cmp_gt, cmp_eq, cmp_lt,
      output trial, busy, done, result, err
   );

   modport slave (
      output start, cmp_gt, cmp_eq, cmp_lt,
      input  trial, busy, done, result, err
   );
endinterface

// File: rtl/sar_mag_search.sv
// Successive-approximation controller: binary-searches an unknown operand by driving
// trial values into an external magnitude comparator and reading back lt/eq/gt.
module sar_mag_search #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 0
) (
   input logic              clk,
   input logic              rst_n,
   sar_mag_search_if.master bus
);
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] trial_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] result_q;
   logic [IW-1:0]    idx_q;
   logic [SW-1:0]    scnt_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic [2:0]       cmp_c;
   logic [WIDTH-1:0] acc_keep_c;
   logic [WIDTH-1:0] next_trial_c;
   logic             step_c;
   state_e           after_trial_c;

   // Keep the current bit on gt, drop it on lt, then probe the next lower bit.
   assign cmp_c         = {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};
   assign acc_keep_c    = bus.cmp_gt ? trial_q : acc_q;
   assign next_trial_c  = acc_keep_c | (WIDTH'(1) << (idx_q - IW'(1)));
   assign step_c        = ((cmp_c == 3'b100) || (cmp_c == 3'b001)) && (idx_q != '0);
   assign after_trial_c = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         trial_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
         scnt_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  acc_q   <= '0;
                  idx_q   <= IW'(WIDTH - 1);
                  trial_q <= WIDTH'(1) << (WIDTH - 1);
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  scnt_q  <= SW'(SETTLE);
                  state_q <= after_trial_c;
               end
            end
            // Counter reaches the sample point after exactly SETTLE idle cycles.
            S_SETTLE: begin
               scnt_q <= scnt_q - SW'(1);
               if (scnt_q <= SW'(1)) state_q <= S_SAMPLE;
            end
            S_SAMPLE: begin
               if (step_c) begin
                  acc_q   <= acc_keep_c;
                  idx_q   <= idx_q - IW'(1);
                  trial_q <= next_trial_c;
                  scnt_q  <= SW'(SETTLE);
                  state_q <= after_trial_c;
               end else begin
                  state_q <= S_DONE;
                  case (cmp_c)
                     3'b010: result_q <= trial_q;
                     3'b100: begin
                        err_q    <= 1'b1;
                        result_q <= trial_q;
                     end
                     3'b001: result_q <= acc_q;
                     default: begin
                        err_q    <= 1'b1;
                        result_q <= acc_q;
                     end
                  endcase
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.trial  = trial_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.err    = err_q;
endmodule
